// File: rtl/clk_tick_gen.sv
// clk_tick_gen: free-running counter plus NCH runtime-programmable divider channels,
// each emitting a 1-cycle tick or a 50%-duty square wave.
module clk_tick_gen #(
    parameter int CNT_W = 32,
    parameter int NCH = 4,
    parameter int DIV_W = 24,
    parameter logic [DIV_W-1:0] DEF_DIV = 24'd50000,
    parameter int CH_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic [CNT_W-1:0] free_cnt,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq,
    output logic [NCH-1:0]   pend
);
    localparam logic [DIV_W-1:0] ONE = 1;
    always_ff @(posedge clk or posedge rst)
        if (rst) free_cnt <= '0;
        else free_cnt <= sync_clr ? '0 : free_cnt + 1'b1;
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIV_W-1:0] c, d, sd, nd;
        logic m, sm, t, s, p, hit, w, nm;
        assign hit = wr_en && wr_ch == CH_W'(i);
        assign w = en && d != '0 && c == d - ONE;
        // a write landing on the wrap edge wins over the older shadow
        assign nd = hit ? wr_div : sd;
        assign nm = hit ? wr_mode : sm;
        assign tick[i] = t;
        assign sq[i] = s;
        assign pend[i] = p;
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                c <= '0;
                d <= DEF_DIV;
                sd <= DEF_DIV;
                m <= 1'b0;
                sm <= 1'b0;
                t <= 1'b0;
                s <= 1'b0;
                p <= 1'b0;
            end else if (sync_clr) begin
                c <= '0;
                d <= sd;
                m <= sm;
                t <= 1'b0;
                s <= 1'b0;
                p <= 1'b0;
            end else begin
                if (hit) begin
                    sd <= wr_div;
                    sm <= wr_mode;
                end
                if (w) begin
                    c <= '0;
                    d <= nd;
                    m <= nm;
                    p <= 1'b0;
                    t <= nm == m && !m;
                    s <= nm == m && m && !s;
                end else if (d == '0) begin
                    // idle channel takes a new divisor on the write edge itself
                    c <= '0;
                    t <= 1'b0;
                    s <= 1'b0;
                    if (hit) begin
                        d <= wr_div;
                        m <= wr_mode;
                    end
                end else begin
                    t <= 1'b0;
                    if (en) c <= c + ONE;
                    if (hit) p <= 1'b1;
                end
            end
    end
endmodule

// File: doc/clk_tick_gen.md
Name: clk_tick_gen

Overview:
- Parametrised successor to the free-running clock-divider counter.
- Keeps the free-running CNT_W-bit count for legacy consumers (VGA, scan, debounce taps).
- Adds NCH independent programmable divider channels. Each channel produces either a 1-cycle tick strobe or a 50%-duty square wave.
- Sits at top level beside the clock input and feeds game-timing logic (tank movement, bullet update, display refresh) with exact, runtime-reprogrammable rates.

Parameters:
- CNT_W, 32, width of free-running counter free_cnt.
- NCH, 4, number of divider channels (1..16).
- DIV_W, 24, width of each channel divisor.
- DEF_DIV, 24'd50000, divisor loaded into every channel at reset.
- CH_W, 4, width of wr_ch; must satisfy 2^CH_W >= NCH.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- en  in  1  global count enable for the divider channels; free_cnt ignores it.
- sync_clr  in  1  synchronous clear of all counters and outputs.
- wr_en  in  1  divisor/mode write strobe.
- wr_ch  in  CH_W  target channel of the write.
- wr_div  in  DIV_W  new divisor; 0 = channel off.
- wr_mode  in  1  0 = tick-pulse mode, 1 = square-wave mode.
- free_cnt  out  CNT_W  free-running counter.
- tick  out  NCH  per-channel 1-cycle strobe (tick mode only, else 0).
- sq  out  NCH  per-channel square wave (square mode only, else 0).
- pend  out  NCH  1 = a written divisor/mode is waiting for that channel's next wrap.

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk; all registers on posedge clk.
- Reset values: free_cnt=0, all channel counters=0, active_div=shadow_div=DEF_DIV, mode=0, tick=0, sq=0, pend=0.
- free_cnt increments by 1 every cycle and wraps 2^CNT_W-1 -> 0. sync_clr forces it to 0. en has no effect on it.
- Per channel i, with D = active_div[i]:
  - Counter cnt[i] counts 0..D-1.
  - Wrap condition W = en & (D!=0) & (cnt==D-1).
  - On W: cnt<=0. In tick mode, tick[i]<=1 for exactly the next cycle. In square mode, sq[i] toggles.
  - When not W and en & D!=0: cnt increments, tick[i]<=0.
- Latency: tick[i] is registered and is high in the cycle after the cycle in which cnt==D-1 is sampled.
  - Tick period is exactly D cycles.
  - Square period is exactly 2D cycles, high D cycles and low D cycles.
- D=1: tick[i] is held high continuously while en=1; sq[i] toggles every cycle.
- en=0: counters and sq hold their values; tick forced 0 on the next edge.
- Writes (wr_en=1, wr_ch<NCH):
  - shadow_div/shadow_mode of the channel <= wr_div/wr_mode; pend[i]<=1.
  - If active_div[i]==0, the new values are applied immediately on the same edge: cnt<=0, pend stays 0.
- Writes with wr_ch>=NCH are ignored with no state change.
- Shadow apply: on W, active_div/mode <= shadow values and pend<=0.
  - If a write to the same channel coincides with W, the written value (not the old shadow) is applied and pend stays 0.
- A mode change clears sq[i] and tick[i] at the apply edge.
- Divisor 0 written to a running channel: the final wrap still occurs and emits its tick. After that the channel is idle: cnt=0, tick=0, sq=0.
- sync_clr (priority over en and writes):
  - free_cnt, all cnt, tick and sq <= 0.
  - Pending shadows are applied immediately; pend <= 0.
  - A wr_en in the same cycle is dropped.
- rst asserted mid-operation returns everything to reset values asynchronously; there is no partial state.
- Arithmetic: compare against D-1 using DIV_W-bit unsigned values. No overflow is possible because cnt < D <= 2^DIV_W-1.

Test Plan:
- Reset release, en=1, DEF_DIV overridden via write to 5 on ch0 (idle apply n/a, so wait for the first wrap) -> after apply, tick[0] pulses every 5 cycles; free_cnt equals the cycle count since reset.
- ch1 written div=3, mode=1 -> sq[1] shows 3 high / 3 low; tick[1]=0 throughout.
- ch2 running at div=10, write div=4 at cnt=2 -> pend[2]=1 until the wrap at cnt=9. The next tick arrives 10 cycles after the previous one, then the tick spacing becomes 4; pend clears at the wrap edge.
- Write div=0 to ch3, then div=7 -> ch3 goes idle after its final tick. The second write applies the same cycle (pend stays 0), and the first tick comes 7 cycles later.
- en low for 20 cycles mid-count on div=8 -> cnt and sq are frozen and tick stays 0. Resuming completes the remaining counts with no extra or missing pulse; free_cnt advances by 20 regardless.
- sync_clr asserted coincident with a wrap and a write; and rst asserted mid-count -> sync_clr: all outputs 0 the next cycle, write dropped, pending shadow applied. rst: all outputs 0 immediately, with no wait for a clock edge.
